// File: rtl/apb_fifo_slave.sv
// APB completer bridging a TX and an RX stream FIFO; writes finish in the first ACCESS cycle, reads add one wait state.
// Streams use valid/ready gated by CTRL.EN. Optional interrupt logic is enabled by defining APB_FIFO_IRQ_EN.

module apb_fifo_slave_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Fullness is judged on the current count, so a pop never frees room for a same-cycle push.
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push_ok && !clr) mem[wr_ptr] <= push_data;
    end
endmodule

module apb_fifo_slave #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [31:0]   PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [DW-1:0] tx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic [DW-1:0] rx_data,
    output logic          irq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [11:0] OFS_CTRL   = 12'h000;
    localparam logic [11:0] OFS_STATUS = 12'h004;
    localparam logic [11:0] OFS_TXDATA = 12'h008;
    localparam logic [11:0] OFS_RXDATA = 12'h00C;
    localparam logic [11:0] OFS_IRQEN  = 12'h010;

    typedef enum logic {IDLE, RD_DATA} state_t;
    state_t state, state_nxt;

    logic          en, ovf, unf;
    logic [31:0]   rd_data_q;
    logic          rd_err_q;
    logic [11:0]   ofs;
    logic          ofs_ok;
    logic          wr_acc, rd_start;
    logic [31:0]   status, rd_mux;
    logic          fifo_clr;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic [CW-1:0] tx_count, rx_count;
    logic [DW-1:0] rx_head;
    logic          unused_bits;
`ifdef APB_FIFO_IRQ_EN
    logic [3:0]    irqen;
`endif

    assign ofs         = PADDR[11:0];
    assign unused_bits = ^{PADDR[31:12], PWDATA};

    always_comb begin
        ofs_ok = 1'b0;
        case (ofs)
            OFS_CTRL, OFS_STATUS, OFS_TXDATA, OFS_RXDATA, OFS_IRQEN: ofs_ok = 1'b1;
            default: ofs_ok = 1'b0;
        endcase
    end

    always_comb begin
        status              = '0;
        status[0]           = tx_empty;
        status[1]           = tx_full;
        status[2]           = rx_empty;
        status[3]           = rx_full;
        status[4]           = ovf;
        status[5]           = unf;
        status[8 +: CW]     = tx_count;
        status[16 +: CW]    = rx_count;
    end

    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_CTRL:   rd_mux = {31'd0, en};
            OFS_STATUS: rd_mux = status;
            OFS_RXDATA: rd_mux = rx_empty ? 32'd0 : 32'(rx_head);
`ifdef APB_FIFO_IRQ_EN
            OFS_IRQEN:  rd_mux = {28'd0, irqen};
`endif
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        wr_acc    = 1'b0;
        rd_start  = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    if (PWRITE) begin
                        wr_acc  = 1'b1;
                        PREADY  = 1'b1;
                        PSLVERR = ~ofs_ok;
                    end else begin
                        rd_start  = 1'b1;
                        state_nxt = RD_DATA;
                    end
                end
            end
            RD_DATA: begin
                PREADY    = 1'b1;
                PSLVERR   = rd_err_q;
                PRDATA    = rd_data_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are combinational from PSEL/PENABLE, so hold them quiet while reset is asserted.
        if (PRESET) begin
            PREADY   = 1'b0;
            PSLVERR  = 1'b0;
            PRDATA   = '0;
            wr_acc   = 1'b0;
            rd_start = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en        <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
`ifdef APB_FIFO_IRQ_EN
            irqen     <= '0;
`endif
        end else begin
            if (wr_acc) begin
                case (ofs)
                    OFS_CTRL: en <= PWDATA[0];
                    OFS_STATUS: begin
                        if (PWDATA[4]) ovf <= 1'b0;
                        if (PWDATA[5]) unf <= 1'b0;
                    end
                    OFS_TXDATA: if (tx_full) ovf <= 1'b1;
`ifdef APB_FIFO_IRQ_EN
                    OFS_IRQEN: irqen <= PWDATA[3:0];
`endif
                    default: ;
                endcase
            end
            if (rd_start) begin
                rd_data_q <= rd_mux;
                rd_err_q  <= ~ofs_ok;
                if (ofs == OFS_RXDATA && rx_empty) unf <= 1'b1;
            end
        end
    end

    assign fifo_clr = wr_acc & (ofs == OFS_CTRL) & PWDATA[1];
    assign tx_valid = ~tx_empty & en;
    assign rx_ready = ~rx_full & en;

    apb_fifo_slave_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .clr       (fifo_clr),
        .push      (wr_acc & (ofs == OFS_TXDATA)),
        .push_data (PWDATA[DW-1:0]),
        .pop       (tx_valid & tx_ready),
        .head      (tx_data),
        .empty     (tx_empty),
        .full      (tx_full),
        .count     (tx_count)
    );

    apb_fifo_slave_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .clr       (fifo_clr),
        .push      (rx_valid & rx_ready),
        .push_data (rx_data),
        .pop       (rd_start & (ofs == OFS_RXDATA) & ~rx_empty),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .count     (rx_count)
    );

`ifdef APB_FIFO_IRQ_EN
    assign irq = |(irqen & {unf, ovf, ~rx_empty, tx_empty});
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed bench for apb_fifo_slave: a queue-based model checked every cycle, plus literal expectations.
module tb_apb_fifo_slave;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_TX = 32'h08,
                            A_RX = 32'h0C, A_IRQEN = 32'h10;

    logic PCLK, PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic PREADY, PSLVERR, tx_valid, tx_ready, rx_valid, rx_ready, irq;
    logic [DW-1:0] tx_data, rx_data;

    int checks = 0;
    int errors = 0;

    apb_fifo_slave #(.DEPTH(DEPTH), .DW(DW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    bit m_en, m_ovf, m_unf, m_pending, m_rderr;
    logic [3:0]  m_irqen = '0;
    logic [31:0] m_rdata = '0;
    int tn, rn;
    bit en_old, clr, push_tx, pop_rx;
    logic [31:0] ofs;

    function automatic bit ofs_valid(input logic [31:0] o);
        return (o <= 32'h10) && (o[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] m_status();
        int t = txq.size();
        int r = rxq.size();
        return 32'((t == 0) + 2*(t == DEPTH) + 4*(r == 0) + 8*(r == DEPTH)
                   + 16*m_ovf + 32*m_unf + 256*t + 65536*r);
    endfunction

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            txq.delete(); rxq.delete();
            m_en = 0; m_ovf = 0; m_unf = 0; m_pending = 0; m_rderr = 0;
            m_irqen = '0; m_rdata = '0;
        end else begin
            tn = txq.size(); rn = rxq.size(); en_old = m_en;
            clr = 0; push_tx = 0; pop_rx = 0;
            ofs = {20'd0, PADDR[11:0]};
            if (m_pending) m_pending = 0;
            else if (PSEL && PENABLE && PWRITE) begin
                case (ofs)
                    A_CTRL:   begin m_en = PWDATA[0]; clr = PWDATA[1]; end
                    A_STATUS: begin if (PWDATA[4]) m_ovf = 0; if (PWDATA[5]) m_unf = 0; end
                    A_TX:     if (tn == DEPTH) m_ovf = 1; else push_tx = 1;
`ifdef APB_FIFO_IRQ_EN
                    A_IRQEN:  m_irqen = PWDATA[3:0];
`endif
                    default: ;
                endcase
            end else if (PSEL && PENABLE) begin
                m_pending = 1;
                m_rderr = !ofs_valid(ofs);
                m_rdata = '0;
                case (ofs)
                    A_CTRL:   m_rdata = {31'd0, m_en};
                    A_STATUS: m_rdata = m_status();
                    A_RX:     if (rn == 0) m_unf = 1; else begin m_rdata = rxq[0]; pop_rx = 1; end
                    A_IRQEN:  m_rdata = {28'd0, m_irqen};
                    default: ;
                endcase
            end
            if (en_old && tn > 0 && tx_ready) void'(txq.pop_front());
            if (push_tx) txq.push_back(PWDATA);
            if (pop_rx) void'(rxq.pop_front());
            if (en_old && rn < DEPTH && rx_valid) rxq.push_back(32'(rx_data));
            if (clr) begin txq.delete(); rxq.delete(); end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit exp_txv, exp_irq, wr_now;
    always @(negedge PCLK) begin
        exp_txv = m_en && txq.size() > 0;
        check("tx_valid", tx_valid, exp_txv);
        if (exp_txv) check("tx_data", tx_data, txq[0]);
        check("rx_ready", rx_ready, m_en && rxq.size() < DEPTH);
`ifdef APB_FIFO_IRQ_EN
        exp_irq = (m_irqen[0] && txq.size() == 0) || (m_irqen[1] && rxq.size() > 0)
               || (m_irqen[2] && m_ovf) || (m_irqen[3] && m_unf);
`else
        exp_irq = 0;
`endif
        check("irq", irq, exp_irq);
        wr_now = !PRESET && !m_pending && PSEL && PENABLE && PWRITE;
        check("pready", PREADY, m_pending || wr_now);
        check("pslverr", PSLVERR, m_pending ? m_rderr : (wr_now && !ofs_valid({20'd0, PADDR[11:0]})));
        check("prdata", PRDATA, m_pending ? m_rdata : 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1;
        @(negedge PCLK); err = PSLVERR;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err, output int waits);
        bit got;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK); #1 PENABLE = 1;
        got = 0; waits = 0; d = '0; err = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge PCLK);
            if (PREADY) begin got = 1; d = PRDATA; err = PSLVERR; end
            else begin waits++; @(posedge PCLK); #1; end
        end
        check("rd_timeout", got, 1);
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic rd_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d; logic e; int w;
        apb_read(a, d, e, w);
        check(name, d, exp);
    endtask

    task automatic rx_push(input logic [31:0] d);
        rx_valid = 1; rx_data = d;
        @(posedge PCLK); #1 rx_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    logic [31:0] rdat, last;
    logic rerr, werr;
    int waits;
    logic [31:0] drained[$];

    initial begin
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        repeat (2) @(negedge PCLK);
        check("rst_pready", PREADY, 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_txvalid", tx_valid, 0);
        check("rst_irq", irq, 0);
        @(posedge PCLK); #1 PRESET = 0;
        rd_expect("status_reset", A_STATUS, 32'h5);

        // single word passes straight through with the consumer ready
        tx_ready = 1;
        wr(A_CTRL, 32'h1);
        wr(A_TX, 32'hA5);
        @(negedge PCLK);
        check("tx_one_valid", tx_valid, 1);
        check("tx_one_data", tx_data, 32'hA5);
        @(negedge PCLK);
        check("tx_one_gone", tx_valid, 0);
        @(posedge PCLK); #1 tx_ready = 0;
        rd_expect("status_tx_empty", A_STATUS, 32'h5);

        // overflow: ninth word dropped
        for (int i = 0; i < 9; i++) wr(A_TX, 32'h100 + i);
        rd_expect("status_tx_full", A_STATUS, 32'h816);
        tx_ready = 1;
        for (int i = 0; i < 14; i++) begin
            @(negedge PCLK);
            if (tx_valid) drained.push_back(tx_data);
        end
        @(posedge PCLK); #1 tx_ready = 0;
        last = (drained.size() > 0) ? drained[drained.size()-1] : 32'd0;
        check("drain_count", drained.size(), 8);
        check("drain_last", last, 32'h107);

        // RX reads with one wait state, then underflow
        rx_push(32'h11);
        rx_push(32'h22);
        apb_read(A_RX, rdat, rerr, waits);
        check("rx_rd1_data", rdat, 32'h11);
        check("rx_rd1_waits", waits, 1);
        apb_read(A_RX, rdat, rerr, waits);
        check("rx_rd2_data", rdat, 32'h22);
        check("rx_rd2_waits", waits, 1);
        rd_expect("rx_rd3_empty", A_RX, 32'h0);
        rd_expect("status_ovf_unf", A_STATUS, 32'h35);

        // unmapped offsets and W1C
        apb_read(32'h20, rdat, rerr, waits);
        check("bad_rd_err", rerr, 1);
        apb_write(32'h24, 32'hFFFF_FFFF, werr);
        check("bad_wr_err", werr, 1);
        rd_expect("status_unchanged", A_STATUS, 32'h35);
        wr(A_STATUS, 32'h30);
        rd_expect("status_w1c", A_STATUS, 32'h5);

        // CLR flushes a partly filled RX FIFO
        for (int i = 0; i < 4; i++) rx_push(32'h31 + i);
        rd_expect("status_rx4", A_STATUS, 32'h40001);
        wr(A_CTRL, 32'h3);
        @(negedge PCLK);
        check("clr_rx_ready", rx_ready, 1);
        rd_expect("status_after_clr", A_STATUS, 32'h5);
        rd_expect("ctrl_readback", A_CTRL, 32'h1);

        // IRQEN register and interrupt level
        apb_write(A_IRQEN, 32'h1, werr);
        check("irqen_wr_err", werr, 0);
        @(negedge PCLK);
`ifdef APB_FIFO_IRQ_EN
        rd_expect("irqen_read", A_IRQEN, 32'h1);
        check("irq_tx_empty", irq, 1);
`else
        rd_expect("irqen_read", A_IRQEN, 32'h0);
        check("irq_tied", irq, 0);
`endif
        wr(A_TX, 32'h99);
        @(negedge PCLK);
        check("irq_tx_nonempty", irq, 0);
        rd_expect("status_tx1", A_STATUS, 32'h104);

        // CLR coinciding with an RX push and a TX pop
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = A_CTRL; PWDATA = 32'h3;
        @(posedge PCLK); #1 PENABLE = 1; rx_valid = 1; rx_data = 32'h77; tx_ready = 1;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; rx_valid = 0; tx_ready = 0;
        rd_expect("status_clr_wins", A_STATUS, 32'h5);

        // reset during a read
        rx_push(32'h55);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = A_RX;
        @(posedge PCLK); #1 PENABLE = 1;
        @(posedge PCLK); #2 PRESET = 1; PSEL = 0; PENABLE = 0;
        @(negedge PCLK);
        check("midrd_rst_pready", PREADY, 0);
        @(posedge PCLK); @(posedge PCLK); #1 PRESET = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("midrd_no_pready", PREADY, 0);
        end
        @(posedge PCLK); #1;
        rd_expect("ctrl_after_rst", A_CTRL, 32'h0);
        rd_expect("status_after_rst", A_STATUS, 32'h5);

        repeat (2) @(posedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_fifo_slave.md
APB_FIFO_SLAVE -- requirements
Module: apb_fifo_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth per direction; power of two, 2..16.
REQ-002 SHALL have parameter DW, default 32, stream data width; 1..32.
REQ-003 SHALL have port PCLK  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port PRESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports PSEL in 1, PENABLE in 1, PWRITE in 1, PADDR in 32, PWDATA in 32, with standard APB completer meaning.
REQ-006 SHALL have port PRDATA  out  32  read data, valid only when PREADY=1, else 0.
REQ-007 SHALL have port PREADY  out  1  transfer complete.
REQ-008 SHALL have port PSLVERR  out  1  error, qualified by PREADY.
REQ-009 SHALL have ports tx_valid out 1, tx_ready in 1, tx_data out DW: TX FIFO head toward the consumer.
REQ-010 SHALL have ports rx_valid in 1, rx_ready out 1, rx_data in DW: producer into the RX FIFO.
REQ-011 SHALL have port irq  out  1  level interrupt.

Function
REQ-012 SHALL decode PADDR[11:0] only: 0x00 CTRL, 0x04 STATUS, 0x08 TXDATA, 0x0C RXDATA, 0x10 IRQEN.
REQ-013 SHALL complete any access to other offsets with PREADY=1 and PSLVERR=1, without side effects.
REQ-014 CTRL SHALL be RW: bit0 EN; bit1 CLR, write-1 flushes both FIFOs that edge and reads 0.
REQ-015 STATUS SHALL be RO except W1C bits: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] OVF sticky, [5] UNF sticky, [12:8] tx_count, [20:16] rx_count.
REQ-016 Writes SHALL complete in the first ACCESS cycle (PREADY=1 combinationally), taking effect on that edge.
REQ-017 Reads SHALL use FSM IDLE->RD_DATA: in IDLE with PSEL&PENABLE&!PWRITE, PREADY=0 and the data is latched (RXDATA popped) on that edge; in RD_DATA, PREADY=1 with the latched PRDATA; then return to IDLE.
REQ-018 Each read transaction SHALL pop RXDATA exactly once.
REQ-019 A write to TXDATA while tx_full SHALL drop the data, set OVF, and complete normally.
REQ-020 A read of RXDATA while rx_empty SHALL return 0, set UNF, and perform no pop.
REQ-021 tx_valid SHALL be !tx_empty & EN; tx_data SHALL be the FIFO head; a pop occurs when tx_valid&tx_ready.
REQ-022 rx_ready SHALL be !rx_full & EN; a push occurs when rx_valid&rx_ready.
REQ-023 A push SHALL be accepted only when the FIFO is not full at that cycle (no bypass); a simultaneous push and pop SHALL leave the count unchanged.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; counts SHALL range 0..DEPTH.
REQ-025 TXDATA writes SHALL store PWDATA[DW-1:0]; RXDATA reads SHALL zero-extend to 32 bits.
REQ-026 CLR with a simultaneous push or pop SHALL win; the FIFO is empty on the next cycle.

Reset
REQ-027 PRESET SHALL force: FSM IDLE, CTRL=0, IRQEN=0, OVF=UNF=0, both FIFOs empty, PREADY=0, PSLVERR=0, PRDATA=0, tx_valid=0, rx_ready=0, irq=0.
REQ-028 Reset asserted mid-read SHALL abandon the transfer; no PREADY SHALL follow release.

Configuration
REQ-029 Macro APB_FIFO_IRQ_EN defined: IRQEN is RW bits[3:0]; irq = |(IRQEN & {UNF, OVF, !rx_empty, tx_empty}).
REQ-030 Macro APB_FIFO_IRQ_EN undefined: IRQEN reads 0 and ignores writes but is not an error; irq is tied to 0.

Verification
REQ-031 Write CTRL=1, write TXDATA 0xA5, hold tx_ready=1 -> tx_valid=1 with tx_data=0xA5 for one cycle, then tx_empty=1.
REQ-032 With EN=1 and tx_ready=0, 9 TXDATA writes (DEPTH=8) -> tx_count=8, tx_full=1, OVF=1; 9th word absent from the drain.
REQ-033 Drive rx_valid with 0x11, 0x22; read RXDATA twice -> each read has PREADY low for 1 ACCESS cycle, then returns 0x11, then 0x22; a third read returns 0 and sets UNF.
REQ-034 Read offset 0x20 -> PREADY=1, PSLVERR=1, no state change; write 0x30 to STATUS -> OVF and UNF cleared.
REQ-035 Fill RX with 4 words, write CTRL=3 -> rx_count=0 next cycle, CTRL reads 0x1.
REQ-036 With the macro defined, IRQEN=0x1 and TX empty -> irq=1; after a TXDATA write with tx_ready=0 -> irq=0.
